// File: rtl/alu_pkg.sv
// Shared opcode encoding, mul/div FSM states and decode helpers for the ALU with
// an iterative multiply/divide unit.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_XOR   = 4'd3;
    localparam logic [3:0] OP_NOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_SLT   = 4'd7;
    localparam logic [3:0] OP_SLTU  = 4'd8;
    localparam logic [3:0] OP_MULT  = 4'd9;
    localparam logic [3:0] OP_MULTU = 4'd10;
    localparam logic [3:0] OP_DIV   = 4'd11;
    localparam logic [3:0] OP_DIVU  = 4'd12;
    localparam logic [3:0] OP_MFHI  = 4'd13;
    localparam logic [3:0] OP_MFLO  = 4'd14;
    localparam logic [3:0] OP_RSVD  = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_e;

    function automatic logic is_md(input logic [3:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_md_md_unit.sv
// Iterative multiply/divide unit: works on operand magnitudes for WIDTH cycles,
// then applies sign correction and writes HI/LO in a single FIX cycle.
module md_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sel,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    md_state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opb_q, hi_q, lo_q;
    logic             is_div_q, neg_res_q, neg_rem_q, done_q;

    logic             a_neg, b_neg, accept;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign accept = start && (state_q == IDLE);
    assign a_neg  = signed_op && a[WIDTH-1];
    assign b_neg  = signed_op && b[WIDTH-1];
    assign a_mag  = a_neg ? -a : a;
    assign b_mag  = b_neg ? -b : b;

    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opb_q};
    // Remainder stays below the divisor, so a WIDTH-bit difference is exact.
    assign div_diff  = div_shift[WIDTH-1:0] - opb_q;

    assign prod     = {acc_hi_q, acc_lo_q};
    assign prod_fix = neg_res_q ? -prod : prod;
    assign quo_fix  = neg_res_q ? -acc_lo_q : acc_lo_q;
    assign rem_fix  = neg_rem_q ? -acc_hi_q : acc_hi_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    if (cnt_q == '0) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state_q == FIX);
            if (accept) begin
                cnt_q     <= CNT_MAX;
                acc_hi_q  <= '0;
                acc_lo_q  <= a_mag;
                opb_q     <= b_mag;
                is_div_q  <= sel;
                neg_res_q <= a_neg ^ b_neg;
                neg_rem_q <= a_neg;
            end else if (state_q == CALC) begin
                if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                if (is_div_q) begin
                    acc_hi_q <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                    acc_lo_q <= {acc_lo_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_hi_q <= mul_sum[WIDTH:1];
                    acc_lo_q <= {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end
            end else if (state_q == FIX) begin
                if (is_div_q) begin
                    // Zero divisor leaves the dividend as remainder; quotient forced to all ones.
                    hi_q <= rem_fix;
                    lo_q <= (opb_q == '0) ? '1 : quo_fix;
                end else begin
                    hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                    lo_q <= prod_fix[WIDTH-1:0];
                end
            end
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/alu_md.sv
// Single-cycle ALU for the EX stage with an attached iterative mul/div unit
// driving the architectural HI/LO registers.
module alu_md
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic [OP_W-1:0]  op,
    input  logic             start,
    output logic [WIDTH-1:0] ans,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned SH_W = $clog2(WIDTH);

    logic [WIDTH-1:0] sum, diff;
    logic             md_start, md_sel, md_signed;

    assign sum  = num1 + num2;
    assign diff = num1 - num2;

    assign md_start  = start && is_md(op);
    assign md_sel    = (op == OP_DIV) || (op == OP_DIVU);
    assign md_signed = (op == OP_MULT) || (op == OP_DIV);

    always_comb begin
        ans      = '0;
        overflow = 1'b0;
        case (op)
            OP_AND:  ans = num1 & num2;
            OP_OR:   ans = num1 | num2;
            OP_ADD: begin
                ans      = sum;
                overflow = (num1[WIDTH-1] == num2[WIDTH-1]) && (sum[WIDTH-1] != num1[WIDTH-1]);
            end
            OP_XOR:  ans = num1 ^ num2;
            OP_NOR:  ans = ~(num1 | num2);
            OP_SLL:  ans = num2 << num1[SH_W-1:0];
            OP_SUB: begin
                ans      = diff;
                overflow = (num1[WIDTH-1] != num2[WIDTH-1]) && (diff[WIDTH-1] != num1[WIDTH-1]);
            end
            OP_SLT:  ans = {{(WIDTH-1){1'b0}}, $signed(num1) < $signed(num2)};
            OP_SLTU: ans = {{(WIDTH-1){1'b0}}, num1 < num2};
            OP_MFHI: ans = hi;
            OP_MFLO: ans = lo;
            default: ans = '0;
        endcase
    end

    assign zero = (ans == '0);

    md_unit #(
        .WIDTH(WIDTH)
    ) u_md_unit (
        .clk       (clk),
        .rst       (rst),
        .start     (md_start),
        .sel       (md_sel),
        .signed_op (md_signed),
        .a         (num1),
        .b         (num2),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md: directed vector table, multi-cycle corner
// sequences and random stimulus against an arithmetic reference model.
module tb_alu_md;
    import alu_pkg::*;

    localparam int W = 32;

    logic          clk, rst, start, zero, overflow, busy, done;
    logic [W-1:0]  num1, num2, ans, hi, lo;
    logic [3:0]    op;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_cnt = 0;
    logic [W-1:0] m_hi, m_lo;

    alu_md #(.WIDTH(W), .OP_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .num1     (num1),
        .num2     (num2),
        .op       (op),
        .start    (start),
        .ans      (ans),
        .zero     (zero),
        .overflow (overflow),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] ans;
        logic         ovf;
        logic         zr;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference for the combinational ops, from plain integer arithmetic.
    task automatic alu_model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                             output logic [W-1:0] r, output logic ovf);
        longint smax, smin, s;
        smax = 64'sd2147483647;
        smin = -smax - 1;
        r = '0;
        ovf = 1'b0;
        case (o)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            OP_ADD: begin
                s = longint'($signed(a)) + longint'($signed(b));
                r = W'(s);
                ovf = (s > smax) || (s < smin);
            end
            OP_SUB: begin
                s = longint'($signed(a)) - longint'($signed(b));
                r = W'(s);
                ovf = (s > smax) || (s < smin);
            end
            OP_SLL:  r = b << (a % W);
            OP_SLT:  r = ($signed(a) < $signed(b)) ? 1 : 0;
            OP_SLTU: r = (a < b) ? 1 : 0;
            OP_MFHI: r = m_hi;
            OP_MFLO: r = m_lo;
            default: r = '0;
        endcase
    endtask

    task automatic md_model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W-1:0] eh, output logic [W-1:0] el);
        logic [63:0] p;
        longint q, r;
        eh = '0;
        el = '0;
        case (o)
            OP_MULT: begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                eh = p[63:32]; el = p[31:0];
            end
            OP_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                eh = p[63:32]; el = p[31:0];
            end
            OP_DIV: begin
                if (b == 0) begin
                    eh = a; el = '1;
                end else begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    eh = W'(r); el = W'(q);
                end
            end
            default: begin
                if (b == 0) begin
                    eh = a; el = '1;
                end else begin
                    eh = a % b; el = a / b;
                end
            end
        endcase
    endtask

    task automatic step();
        if (busy) busy_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op = o; num1 = a; num2 = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        num1 = $urandom;
        num2 = $urandom;
        busy_cnt = 0;
    endtask

    task automatic finish(input string name, input logic [W-1:0] eh, input logic [W-1:0] el);
        int guard = 0;
        while (busy && guard < 200) begin
            busy_cnt++;
            @(posedge clk);
            #1;
            guard++;
        end
        chk({name, " busy cycles"}, 64'(busy_cnt), 64'(W + 1));
        chk({name, " done"}, 64'(done), 64'd1);
        chk({name, " hi"}, 64'(hi), 64'(eh));
        chk({name, " lo"}, 64'(lo), 64'(el));
        op = OP_MFLO;
        #1 chk({name, " mflo"}, 64'(ans), 64'(el));
        op = OP_MFHI;
        #1 chk({name, " mfhi"}, 64'(ans), 64'(eh));
        @(posedge clk);
        #1 chk({name, " done drop"}, 64'(done), 64'd0);
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic run_md(input string name, input logic [3:0] o,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eh, el;
        md_model(o, a, b, eh, el);
        issue(o, a, b);
        finish(name, eh, el);
    endtask

    initial begin
        logic [W-1:0] r, eh, el, prev_lo;
        logic         ovf;
        logic [3:0]   o;

        rst = 1'b1; start = 1'b0; op = OP_AND; num1 = '0; num2 = '0;
        m_hi = '0; m_lo = '0;

        vecs[0]  = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0};
        vecs[1]  = '{OP_SUB,  32'd5,        32'd5,        32'h00000000, 1'b0, 1'b1};
        vecs[2]  = '{OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
        vecs[3]  = '{OP_OR,   32'h0000000F, 32'h000000F0, 32'h000000FF, 1'b0, 1'b0};
        vecs[4]  = '{OP_XOR,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1'b0};
        vecs[5]  = '{OP_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[6]  = '{OP_SLL,  32'd4,        32'd1,        32'h00000010, 1'b0, 1'b0};
        vecs[7]  = '{OP_SLL,  32'd33,       32'd3,        32'h00000006, 1'b0, 1'b0};
        vecs[8]  = '{OP_SLT,  32'hFFFFFFFF, 32'd1,        32'h00000001, 1'b0, 1'b0};
        vecs[9]  = '{OP_SLTU, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b0, 1'b1};
        vecs[10] = '{OP_SUB,  32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b1, 1'b0};
        vecs[11] = '{OP_ADD,  32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b0, 1'b1};
        vecs[12] = '{OP_RSVD, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b1};
        vecs[13] = '{OP_MULT, 32'd7,        32'd9,        32'h00000000, 1'b0, 1'b1};
        vecs[14] = '{OP_MFHI, 32'd7,        32'd9,        32'h00000000, 1'b0, 1'b1};

        #12;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        foreach (vecs[i]) begin
            op = vecs[i].op; num1 = vecs[i].a; num2 = vecs[i].b;
            #1;
            chk($sformatf("vec%0d ans", i), 64'(ans), 64'(vecs[i].ans));
            chk($sformatf("vec%0d ovf", i), 64'(overflow), 64'(vecs[i].ovf));
            chk($sformatf("vec%0d zero", i), 64'(zero), 64'(vecs[i].zr));
        end
        @(posedge clk);
        #1;

        issue(OP_MULT, 32'hFFFFFFFF, 32'd5);
        finish("mult", 32'hFFFFFFFF, 32'hFFFFFFFB);
        issue(OP_MULTU, 32'hFFFFFFFF, 32'd5);
        finish("multu", 32'h00000004, 32'hFFFFFFFB);
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        finish("div neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
        issue(OP_DIVU, 32'd7, 32'd2);
        finish("divu", 32'd1, 32'd3);
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        finish("div min", 32'h00000000, 32'h80000000);
        issue(OP_DIVU, 32'h1234, 32'd0);
        finish("divu zero", 32'h00001234, 32'hFFFFFFFF);

        // Start while busy must be ignored; MFLO sees the previous LO.
        prev_lo = m_lo;
        md_model(OP_MULT, 32'd1000, 32'hFFFFFFFD, eh, el);
        issue(OP_MULT, 32'd1000, 32'hFFFFFFFD);
        repeat (8) step();
        op = OP_MULT; num1 = 32'd77; num2 = 32'd55; start = 1'b1;
        step();
        start = 1'b0;
        op = OP_MFLO;
        #1;
        chk("busy mflo", 64'(ans), 64'(prev_lo));
        chk("busy held", 64'(busy), 64'd1);
        finish("ignored start", eh, el);

        // Reset in the middle of a divide.
        issue(OP_DIV, 32'd1000, 32'd7);
        repeat (14) step();
        rst = 1'b1;
        #1;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort hi", 64'(hi), 64'd0);
        chk("abort lo", 64'(lo), 64'd0);
        step();
        chk("abort done a", 64'(done), 64'd0);
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
        repeat (3) begin
            step();
            chk("abort done b", 64'(done), 64'd0);
        end
        issue(OP_MULTU, 32'd3, 32'd4);
        finish("multu after rst", 32'd0, 32'd12);

        for (int i = 0; i < 200; i++) begin
            o = 4'($urandom_range(0, 15));
            op = o; num1 = $urandom; num2 = $urandom;
            if (i % 4 == 0) num2 = num1;
            #1;
            alu_model(o, num1, num2, r, ovf);
            chk($sformatf("rnd%0d op%0d ans", i, o), 64'(ans), 64'(r));
            chk($sformatf("rnd%0d op%0d ovf", i, o), 64'(overflow), 64'(ovf));
            chk($sformatf("rnd%0d op%0d zero", i, o), 64'(zero), 64'(r == 0));
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            logic [W-1:0] a, b;
            o = 4'(9 + $urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            if (i % 3 == 1) b = $urandom_range(1, 300);
            if (i % 3 == 2) b = b | 32'h80000000;
            if (i == 11) b = 0;
            run_md($sformatf("rmd%0d op%0d", i, o), o, a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_md.md
# alu_md

Parametrised ALU with an integrated iterative multiply/divide unit, the successor to the single-cycle 3-bit-op ALU in the pipelined MIPS core. Logic, arithmetic and compare ops complete combinationally in the EX stage. MULT/MULTU/DIV/DIVU run over multiple cycles into architectural HI/LO registers. `busy` is the pipeline stall request.

## Interface
Parameters:
- `WIDTH`, 32, datapath width (even, ≥ 4)
- `OP_W`, 4, opcode width (fixed encoding, see Operation)

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `num1`  in  WIDTH  operand A; dividend for DIV
- `num2`  in  WIDTH  operand B; divisor for DIV
- `op`  in  OP_W  operation select
- `start`  in  1  request for a mul/div op; ignored for other ops
- `ans`  out  WIDTH  combinational result
- `zero`  out  1  `ans == 0`, valid for every op
- `overflow`  out  1  signed overflow of ADD/SUB; 0 for all other ops
- `busy`  out  1  mul/div in progress
- `done`  out  1  one-cycle pulse when HI/LO have just been written
- `hi`  out  WIDTH  HI register
- `lo`  out  WIDTH  LO register

## Operation
- Opcode encoding:
  - 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 5 SLL (`num2 << num1[log2(WIDTH)-1:0]`), 6 SUB, 7 SLT (signed), 8 SLTU.
  - 9 MULT, 10 MULTU, 11 DIV, 12 DIVU, 13 MFHI (`ans=hi`), 14 MFLO (`ans=lo`), 15 reserved.
- Output rules:
  - `ans=0` for op 15 and for ops 9–12.
  - No latches: `zero` is assigned for every op.
  - SLT/SLTU return 1 or 0 zero-extended.
- Mul/div start acceptance: start is accepted when `start=1`, op ∈ {9..12}, and the FSM is in IDLE. The operands and the signedness are captured on that edge.
- Signed ops operate on magnitudes; signs are corrected in a final FIX cycle.
- MULT/MULTU: radix-2 shift-add, one bit per cycle. Result is 2·WIDTH bits, with `hi` = upper half and `lo` = lower half.
- DIV/DIVU: restoring division, one quotient bit per cycle. `lo` = quotient, `hi` = remainder.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Signed MIN / −1: the result falls out of the algorithm as `lo=MIN`, `hi=0`. No trap.
- Divide by zero: `lo` = all ones, `hi` = `num1` as captured. Normal latency.
- FSM states: IDLE → CALC (WIDTH cycles, counter WIDTH-1..0) → FIX (1 cycle; writes `hi`/`lo`) → IDLE.
  - Only an accepted start leaves IDLE.
- `start` while busy is ignored. Operands may change freely after acceptance.
- MFHI/MFLO while busy return the old `hi`/`lo`. Ordering is the pipeline's job, enforced by stalling on `busy`.

## Timing
- Reset values: `hi=0`, `lo=0`, `busy=0`, `done=0`, FSM=IDLE, counter=0.
  - Combinational outputs follow their inputs during reset.
- Combinational ops: zero latency. `ans`, `zero` and `overflow` settle within the same cycle.
- Mul/div cycle sequence, with start accepted at edge E0:
  - `busy=1` from E0 to E(WIDTH+1).
  - `hi`/`lo` are updated at E(WIDTH+1).
  - `done=1` for exactly the cycle following E(WIDTH+1).
  - `busy=0` in that same cycle.
- A new start may be accepted on the edge that ends the `done` cycle. The earliest re-accept is therefore E(WIDTH+2).
  - No back-to-back start exists in the `done` cycle itself: `busy` is already 0 then, but the FSM is in IDLE only from E(WIDTH+1). Acceptance at E(WIDTH+1) is not possible.
- Reset asserted mid-operation:
  - Aborts immediately and clears `hi`/`lo`.
  - No `done` pulse is produced for the aborted op.
- Overflow detection:
  - ADD: both operands have the same sign and the result sign differs.
  - SUB: operands have differing signs and the result sign differs from `num1`.

## Structure
- Package `alu_pkg`:
  - op-code localparams (`OP_AND`…`OP_MFLO`)
  - FSM state enum (IDLE, CALC, FIX)
  - helper function `is_md(op)`
- Sub-module `md_unit`:
  - holds the FSM, counter, shift registers, sign-fix logic, and HI/LO
  - ports: clk, rst, start, sel (mul/div), signed_op, a, b → busy, done, hi, lo
- `alu_md` holds:
  - the combinational ALU
  - the gating of `start` into `md_unit` (acceptance decoded from `op`)
  - the MFHI/MFLO multiplexing

## Test plan (WIDTH=32)
- ADD 0x7FFFFFFF + 0x00000001 → `ans=0x80000000`, `overflow=1`, `zero=0`. SUB 5 − 5 → `ans=0`, `zero=1`, `overflow=0`.
- MULT 0xFFFFFFFF × 0x00000005 with start → `busy` for 33 cycles, then `done` pulse, `hi=0xFFFFFFFF`, `lo=0xFFFFFFFB`. MULTU with the same operands → `hi=0x00000004`, `lo=0xFFFFFFFB`.
- DIV −7 / 2 → `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`. DIVU 7 / 2 → `lo=3`, `hi=1`. DIV 0x80000000 / 0xFFFFFFFF → `lo=0x80000000`, `hi=0`.
- DIVU 0x1234 / 0 → `lo=0xFFFFFFFF`, `hi=0x1234`, after 33 busy cycles.
- Second start at cycle 10 of a MULT with different operands → ignored, first result unchanged. MFLO at cycle 10 → old `lo`.
- Assert `rst` at cycle 15 of a DIV → `busy=0`, `hi=lo=0` immediately, no `done` pulse. A new MULTU 3 × 4 afterwards → `lo=12`, `hi=0`.
